axis_pattern_gen: RTL and testbench
===================================

// Module: axis_pattern_gen
// PURPOSE
//  Parametrised AXI-Stream test-pattern source for the packet-capture datapath; drives synthetic packets into capture/FIFO logic.
//  Software-style config (length, count, gap, pattern mode) is latched on start. Generation then runs autonomously until done or stopped.
//  Successor to the fixed 8-beat/16-bit-counter generator. Adds runtime length, inter-packet gaps, packet limit and PRBS/lane patterns.
// PARAMETERS
//  DW     512  stream data width in bits; multiple of 32, >= 32
//  LEN_W  16   width of cfg_beats (beats per packet)
//  CNT_W  32   width of cfg_packets and pkt_count
//  GAP_W  8    width of cfg_gap (idle cycles between packets)
// PORTS
//  clk              in   1       clock
//  resetn           in   1       async active-low reset
//  start            in   1       1-cycle pulse: latch cfg_*, begin run (ignored while busy)
//  stop             in   1       1-cycle pulse: finish current packet, then go idle
//  cfg_mode         in   2       pattern: 0=ctr16, 1=lane-ctr16, 2=PRBS31, 3=fixed 0xA5A5
//  cfg_beats        in   LEN_W   beats per packet; 0 treated as 1
//  cfg_packets      in   CNT_W   packets per run; 0 = run until stop
//  cfg_gap          in   GAP_W   idle cycles (TVALID=0) after each TLAST handshake
//  busy             out  1       high from cycle after accepted start until return to IDLE
//  pkt_count        out  CNT_W   packets completed in current/last run; cleared on start
//  AXIS_OUT_TDATA   out  DW      pattern data
//  AXIS_OUT_TKEEP   out  DW/8    all ones
//  AXIS_OUT_TLAST   out  1       high on final beat of each packet
//  AXIS_OUT_TVALID  out  1       beat valid
//  AXIS_OUT_TREADY  in   1       sink ready
// BEHAVIOUR
//  Reset (async, resetn=0): TVALID=0, TLAST=0, busy=0, pkt_count=0, state=IDLE; data regs 0, LFSR=31'h7FFFFFFF. Mid-packet reset aborts immediately.
//  FSM: IDLE -start-> SEND; SEND -TLAST hs, more pkts, gap>0-> GAP; SEND -TLAST hs, more pkts, gap=0-> SEND (back-to-back).
//       SEND -TLAST hs and (limit reached or stop pending)-> IDLE; GAP -gap count expires-> SEND, or IDLE if stop pending.
//  Latency: first TVALID on 2nd cycle after start pulse. All outputs registered.
//  Handshake: beat transfers when TVALID&TREADY. While TVALID=1 and TREADY=0, TDATA/TLAST held stable.
//   TVALID never drops mid-packet except on reset.
//  Beat counter 0..beats-1; TLAST=(beat==beats-1); cfg_beats=1 => every beat TLAST.
//  Pattern state advances only on handshake. Continues across packets, restarts from seed on start.
//   mode0: 16-bit counter c replicated DW/16 times.
//   mode1: lane i (16-bit) = c+i mod 2^16.
//   mode2: PRBS31 x^31+x^28+1, 32-bit word per beat (32 shifts/beat) replicated DW/32.
//   mode3: constant 16'hA5A5 replicated.
//   Counter c wraps 16'hFFFF->0 silently.
//  pkt_count increments on each TLAST handshake; wraps at 2^CNT_W. Limit compare uses count before wrap.
//  stop: latched as stop_pending. In IDLE it has no effect. Same-cycle start+stop in IDLE: start wins, stop dropped.
//   stop during GAP ends run at the gap's end without a further packet.
//  start while busy ignored; cfg_* changes while busy ignored until next start.
// CONFIGURATION
//  PATGEN_SEQ_HDR_EN defined: first beat of every packet has TDATA[31:0] replaced by packet sequence number.
//   Sequence number = pkt_count value before increment. Remaining bits keep pattern; pattern state advances normally.
//  Not defined: TDATA is pure pattern on every beat; no extra logic.
// TESTING
//  T1 mode0, beats=8, packets=3, gap=0, TREADY=1 -> 24 contiguous beats, lane data 0..23, TLAST at beats 7,15,23, pkt_count=3, busy falls.
//  T2 mode1, beats=4, packets=2, gap=5 -> beat0 lanes 0,1,..,31 (DW=512); exactly 5 TVALID=0 cycles between packets.
//  T3 mode2, beats=16, random TREADY (50%) -> TDATA/TLAST stable during stalls; word sequence matches reference PRBS31 model.
//  T4 packets=0, beats=3; stop pulsed on beat 1 of pkt 5 -> pkt 5 completes with TLAST, pkt_count=6, no further TVALID.
//  T5 resetn asserted mid-packet (beat 2 of 8) -> TVALID/busy 0 same edge. Next start restarts at data 0 beat 0.
//  T6 beats=0, wrap: ctr reaches 16'hFFFF -> next beat 0; each beat TLAST; SEQ_HDR_EN build shows seq 0,1,2 in TDATA[31:0].

Source files
------------

// File: rtl/axis_pattern_gen.sv
// AXI-Stream test-pattern source with runtime packet length, packet limit, inter-packet gaps
// and counter / lane-counter / PRBS31 / fixed patterns. Build option PATGEN_SEQ_HDR_EN puts the
// packet sequence number in TDATA[31:0] of each packet's first beat.
module axis_pattern_gen #(
  parameter int DW    = 512,
  parameter int LEN_W = 16,
  parameter int CNT_W = 32,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       cfg_mode,
  input  logic [LEN_W-1:0] cfg_beats,
  input  logic [CNT_W-1:0] cfg_packets,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [DW-1:0]    AXIS_OUT_TDATA,
  output logic [DW/8-1:0]  AXIS_OUT_TKEEP,
  output logic             AXIS_OUT_TLAST,
  output logic             AXIS_OUT_TVALID,
  input  logic             AXIS_OUT_TREADY
);

  localparam int          N16       = DW / 16;
  localparam int          N32       = DW / 32;
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;

  state_t           state, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] packets_q, packets_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] beat, beat_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic [15:0]      ctr, ctr_d;
  logic [30:0]      lfsr, lfsr_d;
  logic             stop_pending, stop_pending_d;
  logic             busy_d;
  logic [CNT_W-1:0] pkt_count_d;
  logic [DW-1:0]    tdata, tdata_d;
  logic             tlast, tlast_d;
  logic             tvalid, tvalid_d;

  logic             hs;
  logic             limit_hit;
  logic [LEN_W-1:0] beat_nxt, last_idx;
  logic [CNT_W-1:0] cnt_inc;
  logic [15:0]      ctr_adv;
  logic [30:0]      lfsr_adv;
  logic [DW-1:0]    pat_cur, pat_adv, first_cur, first_adv;

  // 32 shifts of x^31 + x^28 + 1; the word collects the generated bits, oldest in the MSB.
  function automatic logic [31:0] prbs_word(input logic [30:0] s);
    logic [30:0] r;
    logic [31:0] w;
    r = s;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w = {w[30:0], r[30] ^ r[27]};
      r = {r[29:0], r[30] ^ r[27]};
    end
    return w;
  endfunction

  function automatic logic [30:0] prbs_next(input logic [30:0] s);
    logic [30:0] r;
    r = s;
    for (int i = 0; i < 32; i++) r = {r[29:0], r[30] ^ r[27]};
    return r;
  endfunction

  function automatic logic [DW-1:0] pattern(input logic [1:0] mode, input logic [15:0] c,
                                            input logic [30:0] s);
    logic [DW-1:0] p;
    logic [31:0]   w;
    p = '0;
    w = prbs_word(s);
    case (mode)
      2'd0:    for (int i = 0; i < N16; i++) p[i*16 +: 16] = c;
      2'd1:    for (int i = 0; i < N16; i++) p[i*16 +: 16] = c + 16'(i);
      2'd2:    for (int i = 0; i < N32; i++) p[i*32 +: 32] = w;
      default: for (int i = 0; i < N16; i++) p[i*16 +: 16] = 16'hA5A5;
    endcase
    return p;
  endfunction

  assign hs        = tvalid & AXIS_OUT_TREADY;
  assign beat_nxt  = beat + 1'b1;
  assign last_idx  = beats_q - 1'b1;
  assign cnt_inc   = pkt_count + 1'b1;
  assign limit_hit = (packets_q != '0) && (pkt_count == packets_q - 1'b1);
  assign ctr_adv   = ctr + 1'b1;
  assign lfsr_adv  = prbs_next(lfsr);
  assign pat_cur   = pattern(mode_q, ctr, lfsr);
  assign pat_adv   = pattern(mode_q, ctr_adv, lfsr_adv);

  // First beat of a packet: pattern, optionally tagged with the pre-increment packet count.
  always_comb begin
    first_cur = pat_cur;
    first_adv = pat_adv;
`ifdef PATGEN_SEQ_HDR_EN
    first_cur[31:0] = 32'(pkt_count);
    first_adv[31:0] = 32'(cnt_inc);
`endif
  end

  always_comb begin
    // NOTE: every next value defaults to the current one first, so no branch can infer a latch.
    state_d        = state;
    mode_d         = mode_q;
    beats_d        = beats_q;
    packets_d      = packets_q;
    gap_d          = gap_q;
    beat_d         = beat;
    gap_cnt_d      = gap_cnt;
    ctr_d          = ctr;
    lfsr_d         = lfsr;
    stop_pending_d = stop_pending;
    busy_d         = busy;
    pkt_count_d    = pkt_count;
    tdata_d        = tdata;
    tlast_d        = tlast;
    tvalid_d       = tvalid;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_LOAD;
          busy_d         = 1'b1;
          mode_d         = cfg_mode;
          beats_d        = (cfg_beats == '0) ? LEN_W'(1) : cfg_beats;
          packets_d      = cfg_packets;
          gap_d          = cfg_gap;
          pkt_count_d    = '0;
          ctr_d          = '0;
          lfsr_d         = PRBS_SEED;
          stop_pending_d = 1'b0;
        end
      end

      ST_LOAD: begin
        stop_pending_d = stop_pending | stop;
        state_d        = ST_SEND;
        beat_d         = '0;
        tdata_d        = first_cur;
        tlast_d        = (beats_q == LEN_W'(1));
        tvalid_d       = 1'b1;
      end

      ST_SEND: begin
        stop_pending_d = stop_pending | stop;
        if (hs) begin
          ctr_d  = ctr_adv;
          lfsr_d = lfsr_adv;
          if (!tlast) begin
            beat_d  = beat_nxt;
            tdata_d = pat_adv;
            tlast_d = (beat_nxt == last_idx);
          end else begin
            pkt_count_d = cnt_inc;
            beat_d      = '0;
            tdata_d     = first_adv;
            tlast_d     = (beats_q == LEN_W'(1));
            if (limit_hit || stop_pending || stop) begin
              state_d        = ST_IDLE;
              busy_d         = 1'b0;
              tvalid_d       = 1'b0;
              tlast_d        = 1'b0;
              stop_pending_d = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q - 1'b1;
            end
          end
        end
      end

      ST_GAP: begin
        stop_pending_d = stop_pending | stop;
        if (gap_cnt == '0) begin
          if (stop_pending || stop) begin
            state_d        = ST_IDLE;
            busy_d         = 1'b0;
            tlast_d        = 1'b0;
            stop_pending_d = 1'b0;
          end else begin
            state_d  = ST_SEND;
            tvalid_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      mode_q       <= '0;
      beats_q      <= '0;
      packets_q    <= '0;
      gap_q        <= '0;
      beat         <= '0;
      gap_cnt      <= '0;
      ctr          <= '0;
      lfsr         <= PRBS_SEED;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      pkt_count    <= '0;
      tdata        <= '0;
      tlast        <= 1'b0;
      tvalid       <= 1'b0;
    end else begin
      state        <= state_d;
      mode_q       <= mode_d;
      beats_q      <= beats_d;
      packets_q    <= packets_d;
      gap_q        <= gap_d;
      beat         <= beat_d;
      gap_cnt      <= gap_cnt_d;
      ctr          <= ctr_d;
      lfsr         <= lfsr_d;
      stop_pending <= stop_pending_d;
      busy         <= busy_d;
      pkt_count    <= pkt_count_d;
      tdata        <= tdata_d;
      tlast        <= tlast_d;
      tvalid       <= tvalid_d;
    end
  end

  assign AXIS_OUT_TDATA  = tdata;
  assign AXIS_OUT_TKEEP  = '1;
  assign AXIS_OUT_TLAST  = tlast;
  assign AXIS_OUT_TVALID = tvalid;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: expected beats are queued when a run is started and
// popped by a monitor on the falling edge whenever a beat is accepted.
`timescale 1ns/1ps
module tb_axis_pattern_gen;

  localparam int DW    = 512;
  localparam int LEN_W = 16;
  localparam int CNT_W = 32;
  localparam int GAP_W = 8;
  localparam int KW    = DW / 8;

  logic             clk;
  logic             resetn;
  logic             start;
  logic             stop;
  logic [1:0]       cfg_mode;
  logic [LEN_W-1:0] cfg_beats;
  logic [CNT_W-1:0] cfg_packets;
  logic [GAP_W-1:0] cfg_gap;
  logic             busy;
  logic [CNT_W-1:0] pkt_count;
  logic [DW-1:0]    tdata;
  logic [KW-1:0]    tkeep;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  axis_pattern_gen #(.DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .stop            (stop),
    .cfg_mode        (cfg_mode),
    .cfg_beats       (cfg_beats),
    .cfg_packets     (cfg_packets),
    .cfg_gap         (cfg_gap),
    .busy            (busy),
    .pkt_count       (pkt_count),
    .AXIS_OUT_TDATA  (tdata),
    .AXIS_OUT_TKEEP  (tkeep),
    .AXIS_OUT_TLAST  (tlast),
    .AXIS_OUT_TVALID (tvalid),
    .AXIS_OUT_TREADY (tready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            hs_total = 0;
  int            stall_cnt = 0;
  int            last_gap = -1;
  int            idle_cnt = 0;
  bit            gap_on = 0;
  bit            in_pkt = 0;
  bit            held_valid = 0;
  logic [DW-1:0] held_data;
  logic          held_last;
  bit            rdy_rand = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: stall stability, no mid-packet bubbles, gap length, and scoreboard compare.
  always @(negedge clk) begin
    if (!resetn) begin
      in_pkt     = 0;
      held_valid = 0;
      gap_on     = 0;
    end else begin
      if (held_valid) begin
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== held_data || tlast !== held_last) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b last=%b data=%h required last=%b data=%h",
                   tvalid, tlast, tdata, held_last, held_data);
        end
      end
      if (in_pkt) begin
        n_checks++;
        if (tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_packet_valid: got %b required 1", tvalid);
        end
      end
      if (gap_on) begin
        if (tvalid === 1'b1) begin
          last_gap = idle_cnt;
          gap_on   = 0;
        end else begin
          idle_cnt++;
        end
      end
      held_valid = (tvalid === 1'b1) && (tready === 1'b0);
      held_data  = tdata;
      held_last  = tlast;
      if (held_valid) stall_cnt++;
      if (tvalid === 1'b1 && tready === 1'b1) begin
        hs_total++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data %h with nothing expected", tdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (tdata !== mon_e.data) begin
            n_fail++;
            $display("FAIL beat_data[%0d]: got %h required %h", hs_total, tdata, mon_e.data);
          end
          n_checks++;
          if (tlast !== mon_e.last) begin
            n_fail++;
            $display("FAIL beat_last[%0d]: got %b required %b", hs_total, tlast, mon_e.last);
          end
        end
        in_pkt = (tlast !== 1'b1);
        if (tlast === 1'b1) begin
          gap_on   = 1;
          idle_cnt = 0;
        end
      end
    end
  end

  // Reference model: PRBS31 via x[n] = x[n-31] ^ x[n-28] over a bit history.
  task automatic push_run(input logic [1:0] mode, input int beats, input int npkts);
    int          eff;
    logic [15:0] c;
    bit          hist[$];
    logic [31:0] w;
    beat_t       e;
    eff = (beats == 0) ? 1 : beats;
    c   = '0;
    for (int i = 0; i < 31; i++) hist.push_back(1'b1);
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < eff; b++) begin
        w = '0;
        if (mode == 2'd2) begin
          for (int k = 0; k < 32; k++) begin
            w = {w[30:0], hist[0] ^ hist[3]};
            hist.push_back(w[0]);
            void'(hist.pop_front());
          end
        end
        e.data = '0;
        case (mode)
          2'd0:    for (int i = 0; i < DW/16; i++) e.data[i*16 +: 16] = c;
          2'd1:    for (int i = 0; i < DW/16; i++) e.data[i*16 +: 16] = c + 16'(i);
          2'd2:    for (int i = 0; i < DW/32; i++) e.data[i*32 +: 32] = w;
          default: for (int i = 0; i < DW/16; i++) e.data[i*16 +: 16] = 16'hA5A5;
        endcase
`ifdef PATGEN_SEQ_HDR_EN
        if (b == 0) e.data[31:0] = 32'(p);
`endif
        e.last = (b == eff - 1);
        exp_q.push_back(e);
        c = c + 16'd1;
      end
    end
  endtask

  task automatic do_start(input logic [1:0] mode, input int beats, input int packets,
                          input int gap, input bit with_stop);
    @(posedge clk);
    #1;
    cfg_mode    = mode;
    cfg_beats   = LEN_W'(beats);
    cfg_packets = CNT_W'(packets);
    cfg_gap     = GAP_W'(gap);
    start       = 1'b1;
    stop        = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_total < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (hs_total < target) begin
      n_fail++;
      $display("FAIL %s_wait: %0d beats seen, required %0d", name, hs_total, target);
    end
  endtask

  task automatic check_count(input int required, input string name);
    n_checks++;
    if (pkt_count !== CNT_W'(required)) begin
      n_fail++;
      $display("FAIL %s_pkt_count: got %0d required %0d", name, pkt_count, required);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_mode = '0;
    cfg_beats = '0;
    cfg_packets = '0;
    cfg_gap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b last=%b busy=%b required 0 0 0", tvalid, tlast, busy);
    end
    n_checks++;
    if (pkt_count !== '0 || tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: pkt_count=%0d data=%h required 0", pkt_count, tdata);
    end
    n_checks++;
    if (tkeep !== {KW{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_keep: got %h required all ones", tkeep);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Counter mode, back-to-back packets; stop arriving with start must be dropped.
  task automatic test_basic;
    push_run(2'd0, 8, 3);
    last_gap = -1;
    do_start(2'd0, 8, 3, 0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_first: busy=%b valid=%b required 1 0", busy, tvalid);
    end
    @(negedge clk);
    n_checks++;
    if (tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_second: valid=%b required 1", tvalid);
    end
    wait_idle(200, "basic");
    check_count(3, "basic");
    n_checks++;
    if (last_gap !== 0) begin
      n_fail++;
      $display("FAIL basic_gap: got %0d idle cycles required 0", last_gap);
    end
  endtask

  task automatic test_lane_gap;
    push_run(2'd1, 4, 2);
    last_gap = -1;
    do_start(2'd1, 4, 2, 5, 1'b0);
    wait_idle(200, "lane");
    check_count(2, "lane");
    n_checks++;
    if (last_gap !== 5) begin
      n_fail++;
      $display("FAIL lane_gap: got %0d idle cycles required 5", last_gap);
    end
  endtask

  // PRBS under random backpressure; a start issued mid-run must be ignored.
  task automatic test_prbs_stall;
    push_run(2'd2, 16, 2);
    stall_cnt = 0;
    rdy_rand  = 1;
    do_start(2'd2, 16, 2, 3, 1'b0);
    repeat (3) @(posedge clk);
    do_start(2'd0, 2, 1, 0, 1'b0);
    wait_idle(2000, "prbs");
    rdy_rand = 0;
    check_count(2, "prbs");
    n_checks++;
    if (stall_cnt == 0) begin
      n_fail++;
      $display("FAIL prbs_stalls: got %0d stalled cycles required >0", stall_cnt);
    end
  endtask

  task automatic test_stop_unbounded;
    int base;
    int seen;
    repeat (2) @(posedge clk);
    push_run(2'd3, 3, 6);
    base = hs_total;
    do_start(2'd3, 3, 0, 0, 1'b0);
    wait_hs(base + 16, 500, "stop");
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle(200, "stop");
    check_count(6, "stop");
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (tvalid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL stop_quiet: got %0d valid cycles after stop required 0", seen);
    end
  endtask

  task automatic test_stop_in_gap;
    int base;
    push_run(2'd0, 2, 1);
    base = hs_total;
    do_start(2'd0, 2, 0, 4, 1'b0);
    wait_hs(base + 2, 200, "gapstop");
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle(200, "gapstop");
    check_count(1, "gapstop");
  endtask

  task automatic test_mid_packet_reset;
    int base;
    push_run(2'd0, 8, 1);
    base = hs_total;
    do_start(2'd0, 8, 1, 0, 1'b0);
    wait_hs(base + 2, 200, "rst");
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || pkt_count !== '0) begin
      n_fail++;
      $display("FAIL rst_abort: valid=%b busy=%b pkt_count=%0d required 0 0 0",
               tvalid, busy, pkt_count);
    end
    exp_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    push_run(2'd0, 8, 1);
    do_start(2'd0, 8, 1, 0, 1'b0);
    wait_idle(200, "rst");
    check_count(1, "rst");
  endtask

  // beats=0 acts as 1; run past 16'hFFFF so the counter wraps.
  task automatic test_wrap;
    push_run(2'd0, 0, 65538);
    do_start(2'd0, 0, 65538, 0, 1'b0);
    wait_idle(70000, "wrap");
    check_count(65538, "wrap");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lane_gap;
    test_prbs_stall;
    test_stop_unbounded;
    test_stop_in_gap;
    test_mid_packet_reset;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
